// File: rtl/fighter_pkg.sv
// fighter_pkg: definitions shared by the attack arbiter RTL.
//   fight_state_e    : arbiter FSM states
//   START_VAL        : round-start health/shield value
//   STAT_MIN/MAX     : saturation limits of the 4-bit health/shield counters
//   FIN_*_BIT        : bit positions inside the 2-bit finish output
//   sat_dec/sat_inc  : saturating 4-bit step helpers
package fighter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StCooldown,
    StOver
  } fight_state_e;

  localparam logic [3:0] START_VAL = 4'd10;
  localparam logic [3:0] STAT_MIN  = 4'd0;
  localparam logic [3:0] STAT_MAX  = 4'd15;

  localparam int unsigned FIN_OVER_BIT    = 0;
  localparam int unsigned FIN_P1_LOST_BIT = 1;

  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == STAT_MIN) ? STAT_MIN : v - 4'd1;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == STAT_MAX) ? STAT_MAX : v + 4'd1;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// frame_timer: loadable down-counter stepped by frame_tick.
//   clk, rst_l : clock, asynchronous active-low reset
//   load       : load load_val (wins over counting)
//   load_val   : value to load
//   en         : counting enabled
//   tick       : one-cycle frame pulse
//   done       : combinational pulse on the tick that takes the count from 1 to 0
module frame_timer #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             tick,
  output logic             done
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && tick && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign done = en && tick && (count_q == WIDTH'(1));

endmodule

// File: rtl/attack_arbiter.sv
// attack_arbiter: arbitrates attack requests of two fighters, times the attack and
// cooldown windows in video frames, applies hits to shield/health and detects game over.
// Optional feature: define SHIELD_REGEN_EN to regenerate shields of non-shielding
// players by one every REGEN_FRAMES frames (saturating, never while the game is over).
// Ports:
//   clk, rst_l                     : clock, asynchronous active-low reset
//   frame_tick                     : one-cycle pulse per video frame
//   p1/p2_attack_req               : attack requests (level)
//   p1/p2_shielding                : shield held
//   player_collision               : sprites overlap horizontally
//   p1_facing_p2, p2_facing_p1     : facing flags
//   restart                        : one-cycle new-round pulse
//   p1/p2_attack_grant             : attack active (registered, one-hot or zero)
//   p1/p2_health, p1/p2_shield     : registered 4-bit stats
//   finish                         : [0] game over, [1] p1 lost (registered)
module attack_arbiter #(
  parameter int unsigned ACTIVE_FRAMES   = 8,
  parameter int unsigned COOLDOWN_FRAMES = 16,
  parameter logic [3:0]  START_VAL       = fighter_pkg::START_VAL,
  parameter int unsigned REGEN_FRAMES    = 60
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       frame_tick,
  input  logic       p1_attack_req,
  input  logic       p2_attack_req,
  input  logic       p1_shielding,
  input  logic       p2_shielding,
  input  logic       player_collision,
  input  logic       p1_facing_p2,
  input  logic       p2_facing_p1,
  input  logic       restart,
  output logic       p1_attack_grant,
  output logic       p2_attack_grant,
  output logic [3:0] p1_health,
  output logic [3:0] p2_health,
  output logic [3:0] p1_shield,
  output logic [3:0] p2_shield,
  output logic [1:0] finish
);

  import fighter_pkg::*;

  localparam int unsigned MAX_FRAMES =
      (ACTIVE_FRAMES > COOLDOWN_FRAMES) ? ACTIVE_FRAMES : COOLDOWN_FRAMES;
  localparam int unsigned TW = $clog2(MAX_FRAMES + 1);

  if (ACTIVE_FRAMES == 0 || COOLDOWN_FRAMES == 0 || REGEN_FRAMES == 0) begin : g_cfg_check
    $error("attack_arbiter: frame counts must be non-zero");
  end

  fight_state_e state_q, state_d;
  logic         p1_grant_q, p1_grant_d;
  logic         p2_grant_q, p2_grant_d;
  logic [3:0]   p1_health_q, p1_health_d;
  logic [3:0]   p2_health_q, p2_health_d;
  logic [3:0]   p1_shield_q, p1_shield_d;
  logic [3:0]   p2_shield_q, p2_shield_d;
  logic [1:0]   finish_q, finish_d;
  // Set when p1 won the last grant, so the next tie goes to p2.
  logic         prio_p2_q, prio_p2_d;

  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          timer_en;
  logic          timer_done;
  logic          pick_p1;
  logic          hit;

  // Restart also gates the timer so a coincident frame_tick is dropped.
  assign timer_en = ((state_q == StActive) || (state_q == StCooldown)) && !restart;

  frame_timer #(
    .WIDTH (TW)
  ) u_frame_timer (
    .clk      (clk),
    .rst_l    (rst_l),
    .load     (timer_load),
    .load_val (timer_val),
    .en       (timer_en),
    .tick     (frame_tick),
    .done     (timer_done)
  );

  assign pick_p1 = p1_attack_req && (!p2_attack_req || !prio_p2_q);
  // In ACTIVE exactly one grant register is set and names the attacker.
  assign hit     = player_collision && (p1_grant_q ? p1_facing_p2 : p2_facing_p1);

`ifdef SHIELD_REGEN_EN
  localparam int unsigned RW = (REGEN_FRAMES > 1) ? $clog2(REGEN_FRAMES) : 1;

  logic [RW-1:0] regen_cnt_q;
  logic          regen_run;
  logic          regen_step;

  assign regen_run  = frame_tick && !restart && (state_q != StOver);
  assign regen_step = regen_run && (regen_cnt_q == RW'(REGEN_FRAMES - 1));

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      regen_cnt_q <= '0;
    end else if (restart) begin
      regen_cnt_q <= '0;
    end else if (regen_run) begin
      regen_cnt_q <= regen_step ? '0 : regen_cnt_q + RW'(1);
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    p1_grant_d  = p1_grant_q;
    p2_grant_d  = p2_grant_q;
    p1_health_d = p1_health_q;
    p2_health_d = p2_health_q;
    p1_shield_d = p1_shield_q;
    p2_shield_d = p2_shield_q;
    finish_d    = finish_q;
    prio_p2_d   = prio_p2_q;
    timer_load  = 1'b0;
    timer_val   = '0;

    if (restart) begin
      state_d     = StIdle;
      p1_grant_d  = 1'b0;
      p2_grant_d  = 1'b0;
      p1_health_d = START_VAL;
      p2_health_d = START_VAL;
      p1_shield_d = START_VAL;
      p2_shield_d = START_VAL;
      finish_d    = 2'b00;
      prio_p2_d   = 1'b0;
      timer_load  = 1'b1;
    end else if ((state_q != StOver) &&
                 ((p1_health_q == STAT_MIN) || (p2_health_q == STAT_MIN))) begin
      state_d                   = StOver;
      p1_grant_d                = 1'b0;
      p2_grant_d                = 1'b0;
      finish_d[FIN_OVER_BIT]    = 1'b1;
      finish_d[FIN_P1_LOST_BIT] = (p1_health_q == STAT_MIN);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (p1_attack_req || p2_attack_req) begin
            state_d    = StActive;
            p1_grant_d = pick_p1;
            p2_grant_d = !pick_p1;
            prio_p2_d  = pick_p1;
            timer_load = 1'b1;
            timer_val  = TW'(ACTIVE_FRAMES);
          end
        end
        StActive: begin
          if (timer_done) begin
            state_d    = StCooldown;
            p1_grant_d = 1'b0;
            p2_grant_d = 1'b0;
            timer_load = 1'b1;
            timer_val  = TW'(COOLDOWN_FRAMES);
            if (hit) begin
              if (p1_grant_q) begin
                if (p2_shielding && (p2_shield_q != STAT_MIN)) begin
                  p2_shield_d = sat_dec(p2_shield_q);
                end else begin
                  p2_health_d = sat_dec(p2_health_q);
                end
              end else begin
                if (p1_shielding && (p1_shield_q != STAT_MIN)) begin
                  p1_shield_d = sat_dec(p1_shield_q);
                end else begin
                  p1_health_d = sat_dec(p1_health_q);
                end
              end
            end
          end
        end
        StCooldown: begin
          if (timer_done) begin
            state_d = StIdle;
          end
        end
        StOver: begin
        end
        default: begin
          state_d = StIdle;
        end
      endcase

`ifdef SHIELD_REGEN_EN
      // A shield just drained by a hit is not regenerated in the same cycle.
      if (regen_step) begin
        if (!p1_shielding && (p1_shield_d == p1_shield_q)) begin
          p1_shield_d = sat_inc(p1_shield_q);
        end
        if (!p2_shielding && (p2_shield_d == p2_shield_q)) begin
          p2_shield_d = sat_inc(p2_shield_q);
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= StIdle;
      p1_grant_q  <= 1'b0;
      p2_grant_q  <= 1'b0;
      p1_health_q <= START_VAL;
      p2_health_q <= START_VAL;
      p1_shield_q <= START_VAL;
      p2_shield_q <= START_VAL;
      finish_q    <= 2'b00;
      prio_p2_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      p1_grant_q  <= p1_grant_d;
      p2_grant_q  <= p2_grant_d;
      p1_health_q <= p1_health_d;
      p2_health_q <= p2_health_d;
      p1_shield_q <= p1_shield_d;
      p2_shield_q <= p2_shield_d;
      finish_q    <= finish_d;
      prio_p2_q   <= prio_p2_d;
    end
  end

  assign p1_attack_grant = p1_grant_q;
  assign p2_attack_grant = p2_grant_q;
  assign p1_health       = p1_health_q;
  assign p2_health       = p2_health_q;
  assign p1_shield       = p1_shield_q;
  assign p2_shield       = p2_shield_q;
  assign finish          = finish_q;

endmodule

// File: tb/tb_attack_arbiter.sv
// Self-checking bench for attack_arbiter (default build, regen disabled).
module tb_attack_arbiter;

  localparam int ACT  = 8;
  localparam int COOL = 16;
  localparam int SV   = 10;

  logic       clk = 1'b0;
  logic       rst_l = 1'b1;
  logic       frame_tick = 1'b0;
  logic       p1_req = 1'b0, p2_req = 1'b0;
  logic       p1_sh = 1'b0, p2_sh = 1'b0;
  logic       coll = 1'b0, f12 = 1'b0, f21 = 1'b0;
  logic       restart = 1'b0;
  logic       p1_attack_grant, p2_attack_grant;
  logic [3:0] p1_health, p2_health, p1_shield, p2_shield;
  logic [1:0] finish;
  logic [19:0] dut_vec;

  int tests = 0;
  int fails = 0;

  // Reference model: whose attack is running, frames left in the current window.
  int m_mode;     // 0 waiting, 1 attacking, 2 cooling down, 3 game over
  int m_rem;
  int m_who;      // 0 nobody, 1 p1, 2 p2
  int m_hp1, m_hp2, m_sh1, m_sh2;
  bit m_last_p1;
  bit m_over, m_p1_lost;

  attack_arbiter #(
    .ACTIVE_FRAMES   (ACT),
    .COOLDOWN_FRAMES (COOL),
    .START_VAL       (4'd10),
    .REGEN_FRAMES    (60)
  ) dut (
    .clk              (clk),
    .rst_l            (rst_l),
    .frame_tick       (frame_tick),
    .p1_attack_req    (p1_req),
    .p2_attack_req    (p2_req),
    .p1_shielding     (p1_sh),
    .p2_shielding     (p2_sh),
    .player_collision (coll),
    .p1_facing_p2     (f12),
    .p2_facing_p1     (f21),
    .restart          (restart),
    .p1_attack_grant  (p1_attack_grant),
    .p2_attack_grant  (p2_attack_grant),
    .p1_health        (p1_health),
    .p2_health        (p2_health),
    .p1_shield        (p1_shield),
    .p2_shield        (p2_shield),
    .finish           (finish)
  );

  always #5 clk = ~clk;

  assign dut_vec = {p1_attack_grant, p2_attack_grant, p1_health, p2_health,
                    p1_shield, p2_shield, finish};

  function automatic logic [19:0] model_vec();
    return {m_who == 1, m_who == 2, 4'(m_hp1), 4'(m_hp2), 4'(m_sh1), 4'(m_sh2),
            m_over && m_p1_lost, m_over};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_rem = 0; m_who = 0;
    m_hp1 = SV; m_hp2 = SV; m_sh1 = SV; m_sh2 = SV;
    m_last_p1 = 1'b0; m_over = 1'b0; m_p1_lost = 1'b0;
  endtask

  task automatic model_hit();
    if (m_who == 1 && coll && f12) begin
      if (p2_sh && m_sh2 > 0) m_sh2--;
      else if (m_hp2 > 0) m_hp2--;
    end else if (m_who == 2 && coll && f21) begin
      if (p1_sh && m_sh1 > 0) m_sh1--;
      else if (m_hp1 > 0) m_hp1--;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    if (restart) begin
      model_reset();
      return;
    end
    if (m_mode != 3 && (m_hp1 == 0 || m_hp2 == 0)) begin
      m_mode = 3; m_who = 0; m_over = 1'b1; m_p1_lost = (m_hp1 == 0);
      return;
    end
    case (m_mode)
      0: if (p1_req || p2_req) begin
        if (p1_req && p2_req) m_who = m_last_p1 ? 2 : 1;
        else m_who = p1_req ? 1 : 2;
        m_last_p1 = (m_who == 1);
        m_rem = ACT;
        m_mode = 1;
      end
      1: if (frame_tick) begin
        m_rem--;
        if (m_rem == 0) begin
          model_hit();
          m_who = 0; m_rem = COOL; m_mode = 2;
        end
      end
      2: if (frame_tick) begin
        m_rem--;
        if (m_rem == 0) m_mode = 0;
      end
      default: ;
    endcase
  endtask

  task automatic cyc(input bit tk);
    frame_tick = tk;
    model_step();
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    p1_req = 0; p2_req = 0; p1_sh = 0; p2_sh = 0;
    coll = 0; f12 = 0; f21 = 0; restart = 0;
    rst_l = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_l = 1'b1;
  endtask

  task automatic attack(input bit r1, input bit r2);
    p1_req = r1; p2_req = r2;
    cyc(0);
    p1_req = 0; p2_req = 0;
    repeat (ACT) cyc(1);
    repeat (COOL) cyc(1);
  endtask

  task automatic test_reset();
    #1 rst_l = 1'b0;
    model_reset();
    #2;
    tests++;
    if (dut_vec !== {2'b00, 4'd10, 4'd10, 4'd10, 4'd10, 2'b00}) begin
      fails++; $display("FAIL reset_values: got %h want %h", dut_vec,
                        {2'b00, 4'd10, 4'd10, 4'd10, 4'd10, 2'b00});
    end
    @(posedge clk); #1;
    rst_l = 1'b1;
    cyc(1);
    tests++;
    if (dut_vec !== model_vec()) begin
      fails++; $display("FAIL reset_idle: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_single_hit();
    int n;
    do_reset();
    coll = 1; f12 = 1;
    p1_req = 1; cyc(0); p1_req = 0;
    tests++;
    if ({p1_attack_grant, p2_attack_grant} !== 2'b10) begin
      fails++; $display("FAIL grant_p1: got %b want 10", {p1_attack_grant, p2_attack_grant});
    end
    n = 0;
    while (p1_attack_grant && n < 40) begin
      cyc(1);
      n++;
    end
    tests++;
    if (n != ACT) begin
      fails++; $display("FAIL active_ticks: got %0d want %0d", n, ACT);
    end
    tests++;
    if (p2_health !== 4'd9 || p1_health !== 4'd10) begin
      fails++; $display("FAIL hit_health: got p1=%0d p2=%0d want p1=10 p2=9",
                        p1_health, p2_health);
    end
    tests++;
    if (dut_vec !== model_vec()) begin
      fails++; $display("FAIL hit_model: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_priority();
    do_reset();
    p1_req = 1; p2_req = 1; cyc(0); p1_req = 0; p2_req = 0;
    tests++;
    if ({p1_attack_grant, p2_attack_grant} !== 2'b10) begin
      fails++; $display("FAIL tie_first: got %b want 10", {p1_attack_grant, p2_attack_grant});
    end
    repeat (ACT + COOL) cyc(1);
    p1_req = 1; p2_req = 1; cyc(0); p1_req = 0; p2_req = 0;
    tests++;
    if ({p1_attack_grant, p2_attack_grant} !== 2'b01) begin
      fails++; $display("FAIL tie_second: got %b want 01", {p1_attack_grant, p2_attack_grant});
    end
    repeat (ACT + COOL) cyc(1);
    tests++;
    if (dut_vec !== model_vec()) begin
      fails++; $display("FAIL tie_model: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_shield();
    do_reset();
    coll = 1; f12 = 1; p2_sh = 1;
    attack(1, 0);
    tests++;
    if (p2_shield !== 4'd9 || p2_health !== 4'd10) begin
      fails++; $display("FAIL shield_absorb: got sh=%0d hp=%0d want sh=9 hp=10",
                        p2_shield, p2_health);
    end
    repeat (9) attack(1, 0);
    attack(1, 0);
    tests++;
    if (p2_shield !== 4'd0 || p2_health !== 4'd9) begin
      fails++; $display("FAIL shield_empty: got sh=%0d hp=%0d want sh=0 hp=9",
                        p2_shield, p2_health);
    end
    p2_sh = 0;
  endtask

  task automatic test_game_over();
    bit seen;
    do_reset();
    coll = 1; f12 = 1;
    repeat (9) attack(1, 0);
    tests++;
    if (p2_health !== 4'd1) begin
      fails++; $display("FAIL hp_before_ko: got %0d want 1", p2_health);
    end
    p1_req = 1; cyc(0); p1_req = 0;
    repeat (ACT) cyc(1);
    tests++;
    if (p2_health !== 4'd0 || finish !== 2'b00) begin
      fails++; $display("FAIL ko_edge: got hp=%0d fin=%b want hp=0 fin=00", p2_health, finish);
    end
    cyc(0);
    tests++;
    if (finish !== 2'b01) begin
      fails++; $display("FAIL finish_p2_lost: got %b want 01", finish);
    end
    seen = 0;
    p1_req = 1; p2_req = 1;
    repeat (30) begin
      cyc(1);
      if (p1_attack_grant || p2_attack_grant) seen = 1;
    end
    p1_req = 0; p2_req = 0;
    tests++;
    if (seen || finish !== 2'b01 || p1_health !== 4'd10) begin
      fails++; $display("FAIL over_frozen: got grant_seen=%0d fin=%b p1hp=%0d want 0 01 10",
                        seen, finish, p1_health);
    end
    restart = 1; cyc(1); restart = 0;
    tests++;
    if (dut_vec !== {2'b00, 4'd10, 4'd10, 4'd10, 4'd10, 2'b00}) begin
      fails++; $display("FAIL restart_values: got %h want %h", dut_vec,
                        {2'b00, 4'd10, 4'd10, 4'd10, 4'd10, 2'b00});
    end
  endtask

  task automatic test_cooldown_and_abort();
    int n;
    do_reset();
    p1_req = 1; cyc(0); p1_req = 0;
    repeat (ACT) cyc(1);
    repeat (4) cyc(1);
    p2_req = 1;
    n = 4;
    while (!p2_attack_grant && n < 40) begin
      cyc(1);
      n++;
    end
    p2_req = 0;
    tests++;
    if (n != COOL + 1) begin
      fails++; $display("FAIL cooldown_len: got %0d want %0d", n, COOL + 1);
    end
    coll = 1; f21 = 1;
    repeat (3) cyc(1);
    #2 rst_l = 1'b0;
    model_reset();
    #1;
    tests++;
    if ({p1_attack_grant, p2_attack_grant} !== 2'b00 || p1_health !== 4'd10) begin
      fails++; $display("FAIL abort: got grants=%b p1hp=%0d want 00 10",
                        {p1_attack_grant, p2_attack_grant}, p1_health);
    end
    @(posedge clk); #1;
    rst_l = 1'b1;
    repeat (ACT + 2) cyc(1);
    tests++;
    if (dut_vec !== model_vec() || p1_health !== 4'd10) begin
      fails++; $display("FAIL abort_no_damage: got %h want %h", dut_vec, model_vec());
    end
    coll = 0; f21 = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      p1_req  = ($urandom_range(0, 3) == 0);
      p2_req  = ($urandom_range(0, 3) == 0);
      p1_sh   = ($urandom_range(0, 3) == 0);
      p2_sh   = ($urandom_range(0, 3) == 0);
      coll    = ($urandom_range(0, 7) != 0);
      f12     = ($urandom_range(0, 3) != 0);
      f21     = ($urandom_range(0, 3) != 0);
      restart = ($urandom_range(0, 1499) == 0);
      cyc($urandom_range(0, 1) == 1);
      restart = 0;
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++;
        $display("FAIL random_cycle_%0d: got %h want %h", i, dut_vec, model_vec());
        if (fails > 40) break;
      end
    end
    p1_req = 0; p2_req = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_hit();
    test_priority();
    test_shield();
    test_game_over();
    test_cooldown_and_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
